exec_datapath: RTL and testbench
================================

// Module: exec_datapath
// PURPOSE
// - Parametrised successor to the single-cycle execute datapath. Contains a register file, an ALU,
//   write-back muxing, a data-memory port and an iterative unsigned multiply/divide unit.
// - Sits between decode/control and the external data memory.
// - An issue handshake lets the control unit stall while multi-cycle ops complete.
// PARAMETERS
// - D_WIDTH  32  datapath/register width (>=8)
// - A_WIDTH   5  register address width; register file holds 2**A_WIDTH entries
// - A0_IDX   10  register index mirrored on a0 output
// PORTS
// - clk          in   1        clock, rising edge
// - rst_n        in   1        synchronous reset, active-low
// - issue_valid  in   1        instruction fields below are valid this cycle
// - issue_ready  out  1        datapath can accept an instruction
// - pc           in   D_WIDTH  PC of issued instruction (jal link = pc+4)
// - alu_ctrl     in   4        alu_op_e operation select
// - alu_src      in   1        0: op2=RD2, 1: op2=imm_op
// - imm_op       in   D_WIDTH  sign-extended immediate
// - ad1/ad2/ad3  in   A_WIDTH  rs1 / rs2 / rd addresses
// - we3          in   1        register write enable
// - mem_write    in   1        data-memory store request
// - result_src   in   1        1: write back dmem_rdata
// - jal_sel      in   1        1: write back pc+4
// - eq           out  1        RD1 == op2 (combinational)
// - lt           out  1        signed RD1 < op2 (combinational)
// - sum          out  D_WIDTH  ALU result (combinational, single-cycle ops)
// - dmem_addr    out  D_WIDTH  = sum
// - dmem_wdata   out  D_WIDTH  = RD2
// - dmem_we      out  1        = mem_write & issue_valid & issue_ready
// - dmem_rdata   in   D_WIDTH  combinational read data
// - wb_valid     out  1        register written on this clock edge
// - a0           out  D_WIDTH  register A0_IDX contents
// BEHAVIOUR
// - Reset (rst_n=0 at edge):
//   - all registers <= 0; FSM <= IDLE; issue_ready=1; wb_valid=0
//   - any in-flight mul/div is aborted with no write-back
// - x0 reads 0 always; writes to x0 are discarded (wb_valid still asserts).
// - Accept = issue_valid & issue_ready.
// - Single-cycle ops (ADD,SUB,AND,OR,XOR,SLT,SLTU,SLL,SRL,SRA):
//   - write-back = result_src ? dmem_rdata : jal_sel ? pc+4 : sum
//   - written to ad3 on the accepting edge if we3; wb_valid=1 same cycle
//   - shifts use op2[$clog2(D_WIDTH)-1:0]; add/sub wrap modulo 2**D_WIDTH
// - Multi-cycle ops (MUL low, MULHU, DIVU, REMU):
//   - FSM IDLE -> BUSY on accept; RD1, op2, ad3 and we3 are latched
//   - issue_ready=0 for D_WIDTH cycles (one shift-add/restoring-subtract step per cycle)
//   - BUSY -> DONE after step D_WIDTH; DONE writes the result, wb_valid=1, then -> IDLE
//   - latency: accept edge to write edge = D_WIDTH+1 cycles; issue_ready returns 1 in the DONE cycle
//   - DONE is write-only and never accepts a new instruction
//   - while BUSY/DONE, issue_valid is ignored and dmem_we=0
// - Divide by zero: DIVU -> all-ones, REMU -> dividend. No trap.
// - Read of a register in the cycle it is written returns the old value (write at edge).
// CONFIGURATION
// - EXEC_MULDIV_EN defined: MUL/MULHU/DIVU/REMU behave as above.
// - EXEC_MULDIV_EN undefined:
//   - codes 10-13 are single-cycle and write back 0
//   - FSM and muldiv_iter are absent; issue_ready is tied to 1
// STRUCTURE
// - Package exec_pkg holds:
//   - alu_op_e: ADD=0,SUB=1,AND=2,OR=3,XOR=4,SLT=5,SLTU=6,SLL=7,SRL=8,SRA=9,
//     MUL=10,MULHU=11,DIVU=12,REMU=13
//   - exec_state_e: IDLE, BUSY, DONE
// - Sub-module muldiv_iter: start/op/a/b in, busy/done/result out, D_WIDTH-step iterator.
// - Register file and ALU are inline.
// TESTING
// - Reset then ADDI x10,x0,5 (alu_src=1, imm=5, we3) -> wb_valid=1 that edge, a0=5
// - x1=7, x2=7; SUB with alu_src=0 -> eq=1, sum=0; SLT of -1 vs 1 -> lt=1, SLTU result=0
// - MUL x3=x1*x2 (7*7) -> issue_ready low 32 cycles, x3=49 at cycle 33, wb_valid single pulse
// - DIVU 100/0 -> 0xFFFFFFFF; REMU 100/0 -> 100; DIVU 100/7 -> 14; REMU -> 2
// - rst_n low mid-MUL (cycle 10) -> issue_ready=1 next cycle, rd unchanged (0), no wb_valid
// - jal_sel=1, pc=0x40, ad3=1 -> x1=0x44; write to x0 -> x0 still reads 0

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the execute datapath: ALU operation codes, FSM state
// encoding and a small decode helper.
package exec_pkg;

    typedef enum logic [3:0] {
        ADD   = 4'd0,
        SUB   = 4'd1,
        AND   = 4'd2,
        OR    = 4'd3,
        XOR   = 4'd4,
        SLT   = 4'd5,
        SLTU  = 4'd6,
        SLL   = 4'd7,
        SRL   = 4'd8,
        SRA   = 4'd9,
        MUL   = 4'd10,
        MULHU = 4'd11,
        DIVU  = 4'd12,
        REMU  = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } exec_state_e;

    // True for the operations handled by the iterative multiply/divide unit.
    function automatic logic is_muldiv(input alu_op_e op);
        return (op == MUL) || (op == MULHU) || (op == DIVU) || (op == REMU);
    endfunction

endpackage

// File: rtl/exec_if.sv
// Bundle between decode/control (master) and the execute datapath (slave),
// including the data-memory port and status outputs.
//
// Issue handshake: an instruction is taken on a rising edge where
// issue_valid and issue_ready are both high and the datapath is idle. The
// master holds the instruction fields stable while issue_valid is high.
// issue_ready drops while a multi-cycle op iterates and rises again in the
// write-back cycle as an early "free next cycle" hint; an instruction
// presented in that write-back cycle is not taken.
interface exec_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
);
    import exec_pkg::*;

    logic               issue_valid;
    logic               issue_ready;
    logic [D_WIDTH-1:0] pc;
    logic [3:0]         alu_ctrl;
    logic               alu_src;
    logic [D_WIDTH-1:0] imm_op;
    logic [A_WIDTH-1:0] ad1;
    logic [A_WIDTH-1:0] ad2;
    logic [A_WIDTH-1:0] ad3;
    logic               we3;
    logic               mem_write;
    logic               result_src;
    logic               jal_sel;
    logic               eq;
    logic               lt;
    logic [D_WIDTH-1:0] sum;
    logic [D_WIDTH-1:0] dmem_addr;
    logic [D_WIDTH-1:0] dmem_wdata;
    logic               dmem_we;
    logic [D_WIDTH-1:0] dmem_rdata;
    logic               wb_valid;
    logic [D_WIDTH-1:0] a0;
    exec_state_e        state;

    modport master (
        output issue_valid, pc, alu_ctrl, alu_src, imm_op, ad1, ad2, ad3,
               we3, mem_write, result_src, jal_sel, dmem_rdata,
        input  issue_ready, eq, lt, sum, dmem_addr, dmem_wdata, dmem_we,
               wb_valid, a0, state
    );

    modport slave (
        input  issue_valid, pc, alu_ctrl, alu_src, imm_op, ad1, ad2, ad3,
               we3, mem_write, result_src, jal_sel, dmem_rdata,
        output issue_ready, eq, lt, sum, dmem_addr, dmem_wdata, dmem_we,
               wb_valid, a0, state
    );

endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / divide: one shift-add (MUL, MULHU) or one
// restoring-subtract (DIVU, REMU) step per cycle, W steps per operation.
// hi/lo hold {accumulator, multiplier} or {remainder, quotient}.
module muldiv_iter
    import exec_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  alu_op_e      op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);
    localparam int CW = $clog2(W);

    logic [CW-1:0] cnt;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  opnd;
    alu_op_e       op_q;
    logic          is_div;
    logic [W:0]    add_sum;
    logic [W:0]    shifted;
    logic [W:0]    diff;

    assign is_div = (op_q == DIVU) || (op_q == REMU);
    // done marks the cycle whose edge performs the final step.
    assign done   = busy && (cnt == CW'(W - 1));
    assign result = ((op_q == MULHU) || (op_q == REMU)) ? hi : lo;

    // Step datapaths: multiplier adds on lo[0]; divider trial-subtracts.
    always_comb begin
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[W-1]};
        diff    = shifted - {1'b0, opnd};
    end

    // Load operands on start, then iterate until the last step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
            op_q <= ADD;
        end else if (start && !busy) begin
            busy <= 1'b1;
            cnt  <= '0;
            op_q <= op;
            hi   <= '0;
            if ((op == DIVU) || (op == REMU)) begin
                lo   <= a;
                opnd <= b;
            end else begin
                lo   <= b;
                opnd <= a;
            end
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
            if (is_div) begin
                if (!diff[W]) begin
                    hi <= diff[W-1:0];
                    lo <= {lo[W-2:0], 1'b1};
                end else begin
                    hi <= shifted[W-1:0];
                    lo <= {lo[W-2:0], 1'b0};
                end
            end else begin
                hi <= add_sum[W:1];
                lo <= {add_sum[0], lo[W-1:1]};
            end
        end
    end

endmodule

// File: rtl/exec_datapath.sv
// Execute datapath: register file, ALU, write-back mux, data-memory port and
// (when EXEC_MULDIV_EN is defined) an iterative multiply/divide unit with an
// IDLE/BUSY/DONE sequencer. Without EXEC_MULDIV_EN, codes 10-13 are
// single-cycle and produce 0, and issue_ready is always high.
module exec_datapath
    import exec_pkg::*;
#(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5,
    parameter int A0_IDX  = 10
) (
    input  logic  clk,
    input  logic  rst_n,
    exec_if.slave bus
);
    localparam int SH_W = $clog2(D_WIDTH);
    localparam int NREG = 2 ** A_WIDTH;

    logic [D_WIDTH-1:0] regs [NREG];
    logic [D_WIDTH-1:0] rd1;
    logic [D_WIDTH-1:0] rd2;
    logic [D_WIDTH-1:0] op2;
    logic [D_WIDTH-1:0] alu_res;
    logic [D_WIDTH-1:0] wb_data;
    alu_op_e            alu_op;
    logic               accept;
    logic               wr_en;
    logic [A_WIDTH-1:0] wr_addr;
    logic [D_WIDTH-1:0] wr_data;

    assign alu_op = alu_op_e'(bus.alu_ctrl);
    assign rd1    = (bus.ad1 == '0) ? '0 : regs[bus.ad1];
    assign rd2    = (bus.ad2 == '0) ? '0 : regs[bus.ad2];
    assign op2    = bus.alu_src ? bus.imm_op : rd2;

    // Single-cycle ALU; multiply/divide codes read as 0 here.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ADD:     alu_res = rd1 + op2;
            SUB:     alu_res = rd1 - op2;
            AND:     alu_res = rd1 & op2;
            OR:      alu_res = rd1 | op2;
            XOR:     alu_res = rd1 ^ op2;
            SLT:     alu_res = {{(D_WIDTH-1){1'b0}}, ($signed(rd1) < $signed(op2))};
            SLTU:    alu_res = {{(D_WIDTH-1){1'b0}}, (rd1 < op2)};
            SLL:     alu_res = rd1 << op2[SH_W-1:0];
            SRL:     alu_res = rd1 >> op2[SH_W-1:0];
            SRA:     alu_res = $unsigned($signed(rd1) >>> op2[SH_W-1:0]);
            default: alu_res = '0;
        endcase
    end

    assign wb_data = bus.result_src ? bus.dmem_rdata :
                     bus.jal_sel    ? bus.pc + D_WIDTH'(4) : alu_res;

    assign bus.eq         = (rd1 == op2);
    assign bus.lt         = ($signed(rd1) < $signed(op2));
    assign bus.sum        = alu_res;
    assign bus.dmem_addr  = alu_res;
    assign bus.dmem_wdata = rd2;
    assign bus.dmem_we    = bus.mem_write & accept;
    assign bus.wb_valid   = wr_en;
    assign bus.a0         = regs[A0_IDX];

`ifdef EXEC_MULDIV_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state_q;
    logic [A_WIDTH-1:0] rd_q;
    logic               we_q;
    logic               md_op;
    logic               md_busy;
    logic               md_last;
    logic [D_WIDTH-1:0] md_result;

    assign md_op           = is_muldiv(alu_op);
    assign bus.issue_ready = (state_q != ST_BUSY);
    assign accept          = bus.issue_valid & bus.issue_ready & (state_q == ST_IDLE);
    assign bus.state       = exec_state_e'(state_q);

    muldiv_iter #(.W(D_WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept & md_op),
        .op     (alu_op),
        .a      (rd1),
        .b      (op2),
        .busy   (md_busy),
        .done   (md_last),
        .result (md_result)
    );

    // Sequencer: latch destination on a mul/div accept, wait, write back once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && md_op) begin
                        state_q <= ST_BUSY;
                        rd_q    <= bus.ad3;
                        we_q    <= bus.we3;
                    end
                end
                ST_BUSY: begin
                    if (md_last) begin
                        state_q <= ST_DONE;
                    end else if (!md_busy) begin
                        // iterator idle without finishing: recover to IDLE
                        state_q <= ST_IDLE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Write-port select: DONE owns the port, otherwise single-cycle accepts.
    always_comb begin
        wr_en   = rst_n & accept & bus.we3 & ~md_op;
        wr_addr = bus.ad3;
        wr_data = wb_data;
        if (state_q == ST_DONE) begin
            wr_en   = rst_n & we_q;
            wr_addr = rd_q;
            wr_data = md_result;
        end
    end
`else
    assign bus.issue_ready = 1'b1;
    assign accept          = bus.issue_valid;
    assign bus.state       = IDLE;

    // Write-port select: every accepted instruction is single-cycle.
    always_comb begin
        wr_en   = rst_n & accept & bus.we3;
        wr_addr = bus.ad3;
        wr_data = wb_data;
    end
`endif

    // Register file: cleared on reset, x0 never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_exec_datapath.sv
// Bench for exec_datapath: directed scenarios followed by random
// instructions, compared against an arithmetic register-file model.
module tb_exec_datapath;
  import exec_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] model [32];
  logic [4:0]  exp_q [$];

  exec_if #(.D_WIDTH(32), .A_WIDTH(5)) bus ();

  exec_datapath #(.D_WIDTH(32), .A_WIDTH(5), .A0_IDX(10)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference arithmetic straight from the operation definitions
  function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa;
    logic [4:0]         sh;
    p  = {32'd0, a} * {32'd0, b};
    sa = a;
    sh = b[4:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6:  return (a < b) ? 32'd1 : 32'd0;
      7:  return a << sh;
      8:  return a >> sh;
      9:  return sa >>> sh;
      10: return p[31:0];
      11: return p[63:32];
      12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // scoreboard: every wb_valid cycle must match a queued expected write
  always @(negedge clk) begin
    if (bus.wb_valid) begin
      if (exp_q.size() == 0) check("wb_spurious", 32'd1, 32'd0);
      else void'(exp_q.pop_front());
    end
  end

  task automatic idle_inputs();
    bus.issue_valid = 1'b0;
    bus.pc = '0; bus.alu_ctrl = '0; bus.alu_src = 1'b0; bus.imm_op = '0;
    bus.ad1 = '0; bus.ad2 = '0; bus.ad3 = '0; bus.we3 = 1'b0;
    bus.mem_write = 1'b0; bus.result_src = 1'b0; bus.jal_sel = 1'b0;
    bus.dmem_rdata = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_ready", {31'd0, bus.issue_ready}, 32'd1);
    check("rst_state", {30'd0, bus.state}, {30'd0, IDLE});
    check("rst_a0", bus.a0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic read_reg(input int r, input string tag);
    bus.issue_valid = 1'b0;
    bus.ad1 = 5'(r); bus.alu_ctrl = 4'd0; bus.alu_src = 1'b1; bus.imm_op = '0;
    @(negedge clk);
    check(tag, bus.sum, model[r]);
    check("a0", bus.a0, model[10]);
    @(posedge clk); #1;
  endtask

  // driver: issue one instruction, check its outputs, update the model
  task automatic do_op(input int op, input int rs1, input int rs2, input int rd,
                       input logic src, input logic [31:0] imm, input logic we,
                       input logic memw, input logic rsrc, input logic jal,
                       input logic [31:0] pc_v, input logic [31:0] rdata);
    logic [31:0] a, b, res, exp_sum, wb;
    logic        is_md;
    int          busy_cnt;
    a = model[rs1];
    b = src ? imm : model[rs2];
    res = ref_op(op, a, b);
    exp_sum = (op <= 9) ? res : 32'd0;
`ifdef EXEC_MULDIV_EN
    is_md = (op >= 10) && (op <= 13);
`else
    is_md = 1'b0;
`endif
    bus.issue_valid = 1'b1; bus.alu_ctrl = 4'(op); bus.alu_src = src;
    bus.imm_op = imm; bus.ad1 = 5'(rs1); bus.ad2 = 5'(rs2); bus.ad3 = 5'(rd);
    bus.we3 = we; bus.mem_write = memw; bus.result_src = rsrc; bus.jal_sel = jal;
    bus.pc = pc_v; bus.dmem_rdata = rdata;
    if (we) exp_q.push_back(5'(rd));
    @(negedge clk);
    check("ready", {31'd0, bus.issue_ready}, 32'd1);
    check("sum", bus.sum, exp_sum);
    check("eq", {31'd0, bus.eq}, {31'd0, a == b});
    check("lt", {31'd0, bus.lt}, {31'd0, $signed(a) < $signed(b)});
    check("dmem_addr", bus.dmem_addr, exp_sum);
    check("dmem_wdata", bus.dmem_wdata, model[rs2]);
    check("dmem_we", {31'd0, bus.dmem_we}, {31'd0, memw});
    if (is_md) begin
      check("md_accept_wb", {31'd0, bus.wb_valid}, 32'd0);
      @(posedge clk); #1;
      // junk presented while busy must be ignored
      bus.mem_write = 1'b1; bus.we3 = 1'b1; bus.ad3 = 5'd9; bus.alu_ctrl = 4'd0;
      busy_cnt = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (bus.issue_ready) break;
        busy_cnt++;
        check("busy_dmem_we", {31'd0, bus.dmem_we}, 32'd0);
      end
      check("md_latency", busy_cnt, 32'd32);
      check("done_wb_valid", {31'd0, bus.wb_valid}, {31'd0, we});
      check("done_dmem_we", {31'd0, bus.dmem_we}, 32'd0);
      wb = res;
    end else begin
      check("wb_valid", {31'd0, bus.wb_valid}, {31'd0, we});
      wb = rsrc ? rdata : jal ? pc_v + 32'd4 : exp_sum;
    end
    @(posedge clk); #1;
    bus.issue_valid = 1'b0; bus.mem_write = 1'b0; bus.we3 = 1'b0;
    if (we && rd != 0) model[rd] = wb;
  endtask

  initial begin
    int op, rs1, rs2, rd;
    logic src, we, memw, rsrc, jal;
    checks = 0;
    errors = 0;
    reset_dut();

    // directed
    do_op(0, 0, 0, 10, 1, 32'd5, 1, 0, 0, 0, 0, 0);
    check("a0_addi", bus.a0, 32'd5);
    do_op(0, 0, 0, 1, 1, 32'd7, 1, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 2, 1, 32'd7, 1, 0, 0, 0, 0, 0);
    do_op(1, 1, 2, 3, 0, 32'd0, 1, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 4, 1, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 5, 1, 32'd1, 1, 0, 0, 0, 0, 0);
    do_op(5, 4, 5, 6, 0, 32'd0, 1, 0, 0, 0, 0, 0);
    read_reg(6, "slt");
    do_op(6, 4, 5, 7, 0, 32'd0, 1, 0, 0, 0, 0, 0);
    read_reg(7, "sltu");
    do_op(10, 1, 2, 3, 0, 32'd0, 1, 0, 0, 0, 0, 0);
    read_reg(3, "mul");
    do_op(0, 0, 0, 6, 1, 32'd100, 1, 0, 0, 0, 0, 0);
    do_op(0, 0, 0, 12, 1, 32'd7, 1, 0, 0, 0, 0, 0);
    do_op(12, 6, 0, 8, 0, 32'd0, 1, 0, 0, 0, 0, 0);
    read_reg(8, "divu_zero");
    do_op(13, 6, 0, 9, 0, 32'd0, 1, 0, 0, 0, 0, 0);
    read_reg(9, "remu_zero");
    do_op(12, 6, 12, 13, 0, 32'd0, 1, 0, 0, 0, 0, 0);
    read_reg(13, "divu");
    do_op(13, 6, 12, 14, 0, 32'd0, 1, 0, 0, 0, 0, 0);
    read_reg(14, "remu");
    do_op(0, 0, 0, 1, 1, 32'd0, 1, 0, 0, 1, 32'h40, 0);
    read_reg(1, "jal_link");
    do_op(0, 0, 0, 0, 1, 32'd123, 1, 0, 0, 0, 0, 0);
    read_reg(0, "x0");
    do_op(0, 6, 0, 15, 1, 32'd8, 1, 1, 1, 0, 0, 32'hDEAD_BEEF);
    read_reg(15, "load");

    // reset while a multiply is iterating
`ifdef EXEC_MULDIV_EN
    do_op(0, 0, 0, 11, 1, 32'd3, 1, 0, 0, 0, 0, 0);
    bus.issue_valid = 1'b1; bus.alu_ctrl = 4'd10; bus.alu_src = 1'b0;
    bus.ad1 = 5'd11; bus.ad2 = 5'd12; bus.ad3 = 5'd16; bus.we3 = 1'b1;
    @(posedge clk); #1;
    bus.issue_valid = 1'b0; bus.we3 = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    @(negedge clk);
    check("abort_ready", {31'd0, bus.issue_ready}, 32'd1);
    repeat (40) @(posedge clk);
    #1;
    read_reg(16, "abort_rd");
`else
    reset_dut();
    read_reg(1, "post_reset_x1");
`endif

    // random
    for (int n = 0; n < 60; n++) begin
      op   = $urandom_range(0, 13);
      rs1  = $urandom_range(0, 15);
      rs2  = $urandom_range(0, 15);
      rd   = $urandom_range(0, 15);
      src  = 1'($urandom_range(0, 1));
      we   = ($urandom_range(0, 7) != 0);
      memw = (op < 10) && ($urandom_range(0, 3) == 0);
      rsrc = (op < 10) && ($urandom_range(0, 3) == 0);
      jal  = (op < 10) && ($urandom_range(0, 7) == 0);
      do_op(op, rs1, rs2, rd, src, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
            we, memw, rsrc, jal, {$urandom, 2'b00} & 32'hFFFF_FFFC, $urandom);
      read_reg(rd, "rand_rd");
    end

    repeat (2) @(posedge clk);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
